// File: rtl/ui565_pack_pkg.sv
// Shared constants for the RGB565 word packer.
package ui565_pack_pkg;
  localparam int PIX_W = 16;

  // Lane counter width; never below one bit.
  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ui565_pack.sv
// Packs one RGB565 pixel per handshake into OUT_WIDTH-bit words, first pixel in LSBs.
// A vs rising edge flushes any partial word and tags the next frame's first word.
module ui565_pack
  import ui565_pack_pkg::*;
#(
  parameter int OUT_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_vs,
  input  logic                 i_in_valid,
  input  logic [PIX_W-1:0]     i_in_data,
  output logic                 o_in_ready,
  output logic                 o_out_valid,
  output logic [OUT_WIDTH-1:0] o_out_data,
  output logic                 o_out_sof,
  input  logic                 i_out_ready
);
  localparam int N  = OUT_WIDTH / PIX_W;
  localparam int CW = lane_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((OUT_WIDTH % PIX_W) != 0 || OUT_WIDTH < 32) begin : g_bad_width
    $error("ui565_pack: OUT_WIDTH must be a multiple of 16 and at least 32");
  end

  logic                 r_vs_d;
  logic [CW-1:0]        r_cnt;
  logic [OUT_WIDTH-1:0] r_pack;
  logic                 r_sof_pend;
  logic                 r_flush_pend;
  logic                 r_flush_sof;
  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_sof;

  logic                 w_vs_rise;
  logic                 w_slot_free;
  logic                 w_last;
  logic                 w_accept;
  logic                 w_load_full;
  logic                 w_flush_now;
  logic                 w_flush_go;
  logic                 w_flush_sof;
  logic [OUT_WIDTH-1:0] w_pack_wr;

  assign w_vs_rise   = i_vs & ~r_vs_d;
  assign w_slot_free = ~r_out_valid | i_out_ready;
  assign w_last      = (r_cnt == LAST);
  assign o_in_ready  = ~w_vs_rise & ~r_flush_pend & (~w_last | w_slot_free);
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_load_full = w_accept & w_last;

  // A frame edge with a free slot flushes straight away; otherwise it waits in flush_pend.
  assign w_flush_now = w_vs_rise & (r_cnt != '0) & ~r_flush_pend;
  assign w_flush_go  = (r_flush_pend | w_flush_now) & w_slot_free;
  assign w_flush_sof = r_flush_pend ? r_flush_sof : r_sof_pend;

  always_comb begin
    w_pack_wr = r_pack;
    for (int k = 0; k < N; k++) begin
      if (r_cnt == CW'(k)) w_pack_wr[k*PIX_W +: PIX_W] = i_in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d       <= 1'b0;
      r_cnt        <= '0;
      r_pack       <= '0;
      r_sof_pend   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_flush_sof  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sof    <= 1'b0;
    end else begin
      r_vs_d <= i_vs;

      if (w_flush_go) begin
        r_cnt  <= '0;
        r_pack <= '0;
      end else if (w_accept) begin
        r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
        r_pack <= w_last ? '0 : w_pack_wr;
      end

      // The flush word keeps the sof tag of the frame it belongs to.
      if (w_flush_go) begin
        r_flush_pend <= 1'b0;
      end else if (w_flush_now) begin
        r_flush_pend <= 1'b1;
        r_flush_sof  <= r_sof_pend;
      end

      if (w_vs_rise)        r_sof_pend <= 1'b1;
      else if (w_load_full) r_sof_pend <= 1'b0;

      if (w_load_full) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pack_wr;
        r_out_sof   <= r_sof_pend;
      end else if (w_flush_go) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_pack;
        r_out_sof   <= w_flush_sof;
      end else if (r_out_valid & i_out_ready) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_sof   <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_sof   = r_out_sof;
endmodule

// File: tb/tb_ui565_pack.sv
// Bench for ui565_pack at OUT_WIDTH=64: vector table, directed corner sequences,
// then random traffic against a queue-based pixel/word model.
module tb_ui565_pack;
  localparam int W = 64;
  localparam int N = W / 16;

  logic          clk, rst_n, vs, in_valid, in_ready, out_valid, out_sof, out_ready;
  logic [15:0]   in_data;
  logic [W-1:0]  out_data;

  int errors = 0;
  int checks = 0;

  ui565_pack #(.OUT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_vs(vs), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_out_valid(out_valid), .o_out_data(out_data),
    .o_out_sof(out_sof), .i_out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: pixels of the open word, expected words in output order.
  logic [15:0]  cur[$];
  logic [W-1:0] exp_d[$];
  logic         exp_s[$];
  logic         m_sof, m_vs_d, m_rise;
  logic [W-1:0] m_word;

  task automatic push_word(input logic sof);
    m_word = '0;
    foreach (cur[k]) m_word[k*16 +: 16] = cur[k];
    exp_d.push_back(m_word);
    exp_s.push_back(sof);
    cur.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cur.delete(); exp_d.delete(); exp_s.delete();
      m_sof = 1'b0; m_vs_d = 1'b0;
    end else begin
      m_rise = vs & ~m_vs_d;
      m_vs_d = vs;
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: got word %h expected none", out_data);
        end else begin
          chk("sb_data", out_data, exp_d.pop_front());
          chk("sb_sof", W'(out_sof), W'(exp_s.pop_front()));
        end
      end
      if (m_rise) begin
        if (cur.size() != 0) push_word(m_sof);
        m_sof = 1'b1;
      end
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (cur.size() == N) begin
          push_word(m_sof);
          m_sof = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input logic vs_i, input logic v_i, input logic [15:0] d_i, input logic or_i);
    @(posedge clk);
    #1;
    vs = vs_i; in_valid = v_i; in_data = d_i; out_ready = or_i;
    @(negedge clk);
  endtask

  typedef struct {
    logic vs, v; logic [15:0] d; logic ordy;
    logic e_ir, e_ov; logic [W-1:0] e_data; logic e_sof;
  } vec_t;
  vec_t tbl[$];

  task automatic r(input logic vs_i, input logic v_i, input logic [15:0] d_i, input logic or_i,
                   input logic e_ir, input logic e_ov, input logic [W-1:0] e_d, input logic e_s);
    tbl.push_back('{vs_i, v_i, d_i, or_i, e_ir, e_ov, e_d, e_s});
  endtask

  task automatic chk_out(input string nm, input logic ir, input logic ov,
                         input logic [W-1:0] d, input logic s);
    chk({nm, ".in_ready"}, W'(in_ready), W'(ir));
    chk({nm, ".out_valid"}, W'(out_valid), W'(ov));
    chk({nm, ".out_data"}, out_data, d);
    chk({nm, ".out_sof"}, W'(out_sof), W'(s));
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // back-to-back frame, flush on a partial word, vs with nothing pending
    r(1,0,16'h0000,1, 0,0,'0,0);
    r(1,1,16'h0001,1, 1,0,'0,0);
    r(1,1,16'h0002,1, 1,0,'0,0);
    r(1,1,16'h0003,1, 1,0,'0,0);
    r(1,1,16'h0004,1, 1,0,'0,0);
    r(1,1,16'h0005,1, 1,1,64'h0004_0003_0002_0001,1);
    r(1,1,16'h0006,1, 1,0,'0,0);
    r(1,1,16'h0007,1, 1,0,'0,0);
    r(1,1,16'h0008,1, 1,0,'0,0);
    r(0,0,16'h0000,1, 1,1,64'h0008_0007_0006_0005,0);
    r(0,0,16'h0000,1, 1,0,'0,0);
    r(0,1,16'hA000,1, 1,0,'0,0);
    r(0,1,16'hA001,1, 1,0,'0,0);
    r(0,1,16'hA002,1, 1,0,'0,0);
    r(0,1,16'hA003,1, 1,0,'0,0);
    r(0,1,16'hA004,1, 1,1,64'hA003_A002_A001_A000,0);
    r(0,1,16'hA005,1, 1,0,'0,0);
    r(1,1,16'hB000,1, 0,0,'0,0);
    r(1,1,16'hB000,1, 1,1,64'h0000_0000_A005_A004,0);
    r(1,1,16'hB001,1, 1,0,'0,0);
    r(1,1,16'hB002,1, 1,0,'0,0);
    r(1,1,16'hB003,1, 1,0,'0,0);
    r(0,0,16'h0000,1, 1,1,64'hB003_B002_B001_B000,1);
    r(0,0,16'h0000,1, 1,0,'0,0);
    r(1,0,16'h0000,1, 0,0,'0,0);
    r(1,1,16'hC000,1, 1,0,'0,0);
    r(1,1,16'hC001,1, 1,0,'0,0);
    r(1,1,16'hC002,1, 1,0,'0,0);
    r(1,1,16'hC003,1, 1,0,'0,0);
    r(0,0,16'h0000,1, 1,1,64'hC003_C002_C001_C000,1);
    r(0,0,16'h0000,1, 1,0,'0,0);

    repeat (3) @(negedge clk);
    chk_out("reset", 1'b1, 1'b0, '0, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].vs, tbl[i].v, tbl[i].d, tbl[i].ordy);
      chk_out($sformatf("row%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_data, tbl[i].e_sof);
    end

    // backpressure: second word stalls on its last pixel until the slot frees
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 16'hD000 + 16'(k), 0);
      chk("bp_fill.in_ready", W'(in_ready), W'(1'b1));
    end
    for (int k = 4; k < 7; k++) begin
      cyc(0, 1, 16'hD000 + 16'(k), 0);
      chk_out($sformatf("bp_p%0d", k), 1'b1, 1'b1, 64'hD003_D002_D001_D000, 1'b0);
    end
    cyc(0, 1, 16'hD007, 0); chk_out("bp_stall0", 1'b0, 1'b1, 64'hD003_D002_D001_D000, 1'b0);
    cyc(0, 1, 16'hD007, 0); chk_out("bp_stall1", 1'b0, 1'b1, 64'hD003_D002_D001_D000, 1'b0);
    cyc(0, 1, 16'hD007, 1); chk_out("bp_release", 1'b1, 1'b1, 64'hD003_D002_D001_D000, 1'b0);
    cyc(0, 0, 16'h0000, 1); chk_out("bp_word2", 1'b1, 1'b1, 64'hD007_D006_D005_D004, 1'b0);
    cyc(0, 0, 16'h0000, 1); chk_out("bp_idle", 1'b1, 1'b0, '0, 1'b0);

    // frame edge while the output slot is held: flush waits, new pixels blocked
    for (int k = 0; k < 4; k++) cyc(0, 1, 16'hE000 + 16'(k), 0);
    cyc(0, 1, 16'hE004, 0);
    cyc(0, 1, 16'hE005, 0); chk_out("fw_partial", 1'b1, 1'b1, 64'hE003_E002_E001_E000, 1'b0);
    cyc(1, 1, 16'hF000, 0); chk_out("fw_rise", 1'b0, 1'b1, 64'hE003_E002_E001_E000, 1'b0);
    cyc(1, 1, 16'hF000, 0); chk_out("fw_wait", 1'b0, 1'b1, 64'hE003_E002_E001_E000, 1'b0);
    cyc(1, 1, 16'hF000, 1); chk_out("fw_free", 1'b0, 1'b1, 64'hE003_E002_E001_E000, 1'b0);
    cyc(1, 1, 16'hF000, 1); chk_out("fw_flush", 1'b1, 1'b1, 64'h0000_0000_E005_E004, 1'b0);
    cyc(1, 1, 16'hF001, 1);
    cyc(1, 1, 16'hF002, 1);
    cyc(1, 1, 16'hF003, 1);
    cyc(0, 0, 16'h0000, 1); chk_out("fw_next", 1'b1, 1'b1, 64'hF003_F002_F001_F000, 1'b1);
    cyc(0, 0, 16'h0000, 1);

    // async reset with a held word and a pending sof: all of it discarded
    for (int k = 0; k < 4; k++) cyc(0, 1, 16'h6000 + 16'(k), 0);
    cyc(1, 0, 16'h0000, 0); chk_out("rst_pre", 1'b0, 1'b1, 64'h6003_6002_6001_6000, 1'b0);
    cyc(0, 1, 16'h6004, 0);
    cyc(0, 1, 16'h6005, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_out("rst_async", 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc(0, 1, 16'h7000 + 16'(k), 1);
    cyc(0, 0, 16'h0000, 1); chk_out("rst_after", 1'b1, 1'b1, 64'h7003_7002_7001_7000, 1'b0);
    cyc(0, 0, 16'h0000, 1);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic nvs;
      nvs = ($urandom_range(0, 29) == 0) ? ~vs : vs;
      cyc(nvs, ($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 2) != 0));
    end
    repeat (6) cyc(0, 0, 16'h0000, 1);
    chk("sb_drained", W'(exp_d.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
